// File: rtl/direct_mapped_cache_if.sv
// CPU load path and MainMemory fill port of the direct-mapped read cache.
// The cache side uses the slave modport; the requester/memory side uses master.
interface direct_mapped_cache_if;
   localparam int unsigned ADDR_W  = 15;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned BLOCK_W = 128;

   logic [ADDR_W-1:0]  cpu_address;
   logic               cpu_read;
   logic [WORD_W-1:0]  cpu_data;
   logic               cpu_ready;
   logic [ADDR_W-1:0]  mem_address;
   logic               mem_read;
   logic               mem_data_ready;
   logic [BLOCK_W-1:0] mem_data_block;

   modport slave (
      input  cpu_address, cpu_read, mem_data_ready, mem_data_block,
      output cpu_data, cpu_ready, mem_address, mem_read
   );

   modport master (
      output cpu_address, cpu_read, mem_data_ready, mem_data_block,
      input  cpu_data, cpu_ready, mem_address, mem_read
   );
endinterface

// File: rtl/direct_mapped_cache.sv
// Direct-mapped read-only cache: 4-word lines, whole-block fill from MainMemory on miss,
// with hit/miss performance counters.
module direct_mapped_cache #(
   parameter int unsigned INDEX_BITS  = 8,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   direct_mapped_cache_if.slave   bus,
   output logic [COUNT_WIDTH-1:0] hit_count,
   output logic [COUNT_WIDTH-1:0] miss_count
);
   localparam int unsigned TAG_BITS = 13 - INDEX_BITS;
   localparam int unsigned LINES    = 1 << INDEX_BITS;

   typedef enum logic [2:0] {IDLE, COMPARE, MISS_REQ, MISS_WAIT, RESPOND} state_t;

   state_t                 state_q, state_d;
   logic [14:0]            addr_q, addr_d;
   logic [31:0]            cpu_data_q, cpu_data_d;
   logic                   cpu_ready_q, cpu_ready_d;
   logic [14:0]            mem_address_q, mem_address_d;
   logic                   mem_read_q, mem_read_d;
   logic [COUNT_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d;
   logic                   fill_c;

   logic [LINES-1:0]       valid_q;
   logic [TAG_BITS-1:0]    tag_q  [LINES];
   logic [127:0]           data_q [LINES];

   logic [1:0]             offset;
   logic [INDEX_BITS-1:0]  index;
   logic [TAG_BITS-1:0]    tag;
   logic [127:0]           line;

   assign offset = addr_q[1:0];
   assign index  = addr_q[INDEX_BITS+1:2];
   assign tag    = addr_q[14:INDEX_BITS+2];
   assign line   = data_q[index];

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      cpu_data_d    = cpu_data_q;
      cpu_ready_d   = cpu_ready_q;
      mem_address_d = mem_address_q;
      mem_read_d    = mem_read_q;
      hit_d         = hit_q;
      miss_d        = miss_q;
      fill_c        = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cpu_read) begin
               addr_d  = bus.cpu_address;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (valid_q[index] && (tag_q[index] == tag)) begin
               cpu_data_d  = line[{offset, 5'd0} +: 32];
               cpu_ready_d = 1'b1;
               hit_d       = hit_q + COUNT_WIDTH'(1);
               state_d     = RESPOND;
            end else begin
               mem_address_d = addr_q;
               mem_read_d    = 1'b1;
               miss_d        = miss_q + COUNT_WIDTH'(1);
               state_d       = MISS_REQ;
            end
         end
         // dataReady may still be high from the previous fetch; skip one cycle
         MISS_REQ: state_d = MISS_WAIT;
         MISS_WAIT: begin
            if (bus.mem_data_ready) begin
               fill_c      = 1'b1;
               cpu_data_d  = bus.mem_data_block[{offset, 5'd0} +: 32];
               cpu_ready_d = 1'b1;
               mem_read_d  = 1'b0;
               state_d     = RESPOND;
            end
         end
         RESPOND: begin
            if (!bus.cpu_read) begin
               cpu_ready_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, registered outputs and valid bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         cpu_data_q    <= '0;
         cpu_ready_q   <= 1'b0;
         mem_address_q <= '0;
         mem_read_q    <= 1'b0;
         hit_q         <= '0;
         miss_q        <= '0;
         valid_q       <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cpu_data_q    <= cpu_data_d;
         cpu_ready_q   <= cpu_ready_d;
         mem_address_q <= mem_address_d;
         mem_read_q    <= mem_read_d;
         hit_q         <= hit_d;
         miss_q        <= miss_d;
         if (fill_c) valid_q[index] <= 1'b1;
      end
   end

   // Tag and data arrays are not reset; valid bits guard them
   always_ff @(posedge clk) begin
      if (fill_c) begin
         tag_q[index]  <= tag;
         data_q[index] <= bus.mem_data_block;
      end
   end

   assign bus.cpu_data    = cpu_data_q;
   assign bus.cpu_ready   = cpu_ready_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_read    = mem_read_q;
   assign hit_count       = hit_q;
   assign miss_count      = miss_q;
endmodule

// File: tb/tb_direct_mapped_cache.sv
// Scoreboard bench for direct_mapped_cache with a MainMemory model that leaves dataReady
// high after each fill until the next read rise.
module tb_direct_mapped_cache;
   localparam int unsigned CW  = 4;
   localparam int unsigned LAT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] hit_count, miss_count;

   always #5 clk = ~clk;

   direct_mapped_cache_if bus ();

   direct_mapped_cache #(.INDEX_BITS(8), .COUNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   int          rises = 0;
   logic [14:0] rise_addr = '0;
   logic        rd_prev = 1'b0;
   logic        rdy_prev = 1'b0;

   function automatic logic [31:0] mem_word(input logic [14:0] a);
      return {2'b10, a, a};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   // MainMemory model: dataReady drops one cycle after read rises, block arrives LAT cycles later
   initial begin
      logic [14:0] base;
      bus.mem_data_ready = 1'b0;
      bus.mem_data_block = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.mem_read && !rd_prev) begin
            rises++;
            rise_addr = bus.mem_address;
            base = {bus.mem_address[14:2], 2'b00};
            @(posedge clk); #1;
            bus.mem_data_ready = 1'b0;
            repeat (LAT) @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++)
               bus.mem_data_block[32*k +: 32] = mem_word(base | 15'(k));
            bus.mem_data_ready = 1'b1;
         end
         rd_prev = bus.mem_read;
      end
   end

   // Monitor: every new cpu_ready is matched against the oldest expected word
   always @(negedge clk) begin
      if (bus.cpu_ready && !rdy_prev) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready: got data %h, required no response", bus.cpu_data);
         end else begin
            check("cpu_data", bus.cpu_data, exp_q.pop_front());
         end
      end
      rdy_prev = bus.cpu_ready;
   end

   // One read transaction, called at a negedge with the FSM in IDLE
   task automatic rd(input logic [14:0] a, input bit exp_hit, input string name);
      int edges = 0;
      exp_q.push_back(mem_word(a));
      bus.cpu_address = a;
      bus.cpu_read    = 1'b1;
      while (edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (bus.cpu_ready) break;
      end
      check({name, "_ready"}, 32'(bus.cpu_ready), 32'd1);
      check({name, "_latency"}, 32'(edges), exp_hit ? 32'd2 : 32'(4 + LAT));
      bus.cpu_read    = 1'b0;
      bus.cpu_address = 15'h7FFF;
      @(posedge clk);
      @(negedge clk);
      check({name, "_drop"}, 32'(bus.cpu_ready), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int r0;
      rst             = 1'b0;
      bus.cpu_read    = 1'b0;
      bus.cpu_address = '0;
      #12;
      check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
      check("rst_cpu_data", bus.cpu_data, 32'd0);
      check("rst_mem_read", 32'(bus.mem_read), 32'd0);
      check("rst_mem_address", 32'(bus.mem_address), 32'd0);
      check("rst_hit_count", 32'(hit_count), 32'd0);
      check("rst_miss_count", 32'(miss_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Cold miss
      rd(15'h0005, 1'b0, "cold");
      check("cold_miss_count", 32'(miss_count), 32'd1);
      check("cold_hit_count", 32'(hit_count), 32'd0);
      check("cold_rises", 32'(rises), 32'd1);
      check("cold_mem_address", 32'(rise_addr), 32'h0005);

      // Same-block hits
      rd(15'h0004, 1'b1, "hit4");
      rd(15'h0006, 1'b1, "hit6");
      rd(15'h0007, 1'b1, "hit7");
      check("hits_hit_count", 32'(hit_count), 32'd3);
      check("hits_rises", 32'(rises), 32'd1);
      check("hits_mem_read", 32'(bus.mem_read), 32'd0);

      // Conflict on index 1
      do_reset();
      r0 = rises;
      rd(15'h0005, 1'b0, "conf_a");
      rd(15'h0405, 1'b0, "conf_b");
      check("conf_b_mem_address", 32'(rise_addr), 32'h0405);
      rd(15'h0005, 1'b0, "conf_c");
      check("conf_miss_count", 32'(miss_count), 32'd3);
      check("conf_hit_count", 32'(hit_count), 32'd0);
      check("conf_rises", 32'(rises - r0), 32'd3);

      // Miss right after a fill while stale dataReady is still high
      check("stale_ready_high", 32'(bus.mem_data_ready), 32'd1);
      rd(15'h0009, 1'b0, "stale");
      check("stale_miss_count", 32'(miss_count), 32'd4);

      // Reset during MISS_WAIT
      bus.cpu_address = 15'h0100;
      bus.cpu_read    = 1'b1;
      repeat (4) @(negedge clk);
      check("midmiss_mem_read_before", 32'(bus.mem_read), 32'd1);
      rst          = 1'b0;
      bus.cpu_read = 1'b0;
      #1;
      check("midmiss_mem_read_rst", 32'(bus.mem_read), 32'd0);
      check("midmiss_hit_count", 32'(hit_count), 32'd0);
      check("midmiss_miss_count", 32'(miss_count), 32'd0);
      check("midmiss_cpu_ready", 32'(bus.cpu_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (LAT + 6) @(negedge clk);
      check("midmiss_idle_ready", 32'(bus.cpu_ready), 32'd0);
      r0 = rises;
      rd(15'h0100, 1'b0, "reread");
      check("reread_miss_count", 32'(miss_count), 32'd1);
      check("reread_rises", 32'(rises - r0), 32'd1);
      check("reread_mem_address", 32'(rise_addr), 32'h0100);

      // Hit counter wrap at 4 bits
      do_reset();
      rd(15'h0004, 1'b0, "wrap_fill");
      for (int i = 0; i < 17; i++) begin
         rd(15'h0004, 1'b1, "wrap_hit");
         if (i == 14) check("wrap_hit_count_15", 32'(hit_count), 32'd15);
      end
      check("wrap_hit_count", 32'(hit_count), 32'd1);
      check("wrap_miss_count", 32'(miss_count), 32'd1);
      check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
